palette_ram: RTL and testbench

- Writable, parametrised colour-palette memory replacing hard-wired palette tables in the PPU.
- The CPU-side register interface loads and reads entries.
- The pixel pipeline presents {palette_num, color_num} each pixel and receives a registered system colour one cycle later.
- Supports backdrop mirroring: colour 0 of every palette aliases one shared entry.
- A reset-time init sequencer clears the memory.

---
 rtl/palette_ram.sv | 155 +++++++++++++++
 tb/tb_palette_ram.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ram.sv
// Purpose : writable colour-palette memory with CPU load/readback, backdrop mirroring and a clear-on-reset sequencer.
// Latency : pixel lookup and CPU read both return registered data one cycle after the request.
// Backpress: none; one pixel lookup per cycle always accepted, CPU writes/reads dropped while init_busy is high.
module palette_ram #(
   parameter int NUM_PAL         = 4,
   parameter int COLORS          = 4,
   parameter int COLOR_W         = 6,
   parameter int MIRROR_BACKDROP = 1,
   localparam int PW             = $clog2(NUM_PAL),
   localparam int CW             = $clog2(COLORS),
   localparam int AW             = PW + CW,
   localparam int DEPTH          = NUM_PAL * COLORS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_we,
   input  logic               cpu_re,
   input  logic [AW-1:0]      cpu_addr,
   input  logic [COLOR_W-1:0] cpu_wdata,
   output logic [COLOR_W-1:0] cpu_rdata,
   output logic               cpu_rvalid,
   input  logic               pix_valid,
   input  logic [PW-1:0]      palette_num,
   input  logic [CW-1:0]      color_num,
   output logic               out_valid,
   output logic [COLOR_W-1:0] system_color,
   output logic               init_busy
);

   // Counter is one bit wider than the address so DEPTH-1 never aliases with a wrapped value.
   localparam logic [AW:0] INIT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic [COLOR_W-1:0]   mem_q [DEPTH];

   logic                 cpu_rvalid_q, cpu_rvalid_d;
   logic [COLOR_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                 out_valid_q, out_valid_d;
   logic [COLOR_W-1:0]   system_color_q, system_color_d;

   logic                 mem_we;
   logic [AW-1:0]        mem_waddr;
   logic [COLOR_W-1:0]   mem_wdata;
   logic [AW-1:0]        cpu_eff;
   logic [AW-1:0]        pix_eff;

   // Colour 0 of every palette collapses onto entry 0 when backdrop mirroring is enabled.
   function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = a;
      if ((MIRROR_BACKDROP != 0) && (a[CW-1:0] == '0)) begin
         r = '0;
      end
      return r;
   endfunction

   assign cpu_eff = eff_addr(cpu_addr);
   assign pix_eff = eff_addr({palette_num, color_num});

   // State and init counter register; reset always restarts the clear from entry 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: walk every entry once, then stay in RUN until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + CNT_ONE;
         if (cnt_q == INIT_LAST) begin
            state_d = ST_RUN;
         end
      end
   end

   // Single write port shared by the clear sequencer and CPU writes; CPU writes are dropped during INIT.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (rst_n) begin
         if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[AW-1:0];
            mem_wdata = '0;
         end else if (cpu_we) begin
            mem_we    = 1'b1;
            mem_waddr = cpu_eff;
            mem_wdata = cpu_wdata;
         end
      end
   end

   // Storage array; reads elsewhere use the pre-edge contents, giving read-before-write on collisions.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Read-side next values: CPU read only in RUN without a simultaneous write; pixel data forced to 0 in INIT.
   always_comb begin
      cpu_rvalid_d   = 1'b0;
      cpu_rdata_d    = cpu_rdata_q;
      out_valid_d    = pix_valid;
      system_color_d = system_color_q;
      if ((state_q == ST_RUN) && cpu_re && !cpu_we) begin
         cpu_rvalid_d = 1'b1;
         cpu_rdata_d  = mem_q[cpu_eff];
      end
      if (pix_valid) begin
         if (state_q == ST_RUN) begin
            system_color_d = mem_q[pix_eff];
         end else begin
            system_color_d = '0;
         end
      end
   end

   // Output registers; all cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cpu_rvalid_q   <= 1'b0;
         cpu_rdata_q    <= '0;
         out_valid_q    <= 1'b0;
         system_color_q <= '0;
      end else begin
         cpu_rvalid_q   <= cpu_rvalid_d;
         cpu_rdata_q    <= cpu_rdata_d;
         out_valid_q    <= out_valid_d;
         system_color_q <= system_color_d;
      end
   end

   assign cpu_rvalid   = cpu_rvalid_q;
   assign cpu_rdata    = cpu_rdata_q;
   assign out_valid    = out_valid_q;
   assign system_color = system_color_q;
   assign init_busy    = (state_q == ST_INIT);

endmodule

// File: tb/tb_palette_ram.sv
// Purpose : directed bench for palette_ram; default mirrored, default unmirrored and 8x4x8 mirrored instances share one stimulus.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point after the next edge.
// Backpress: not applicable; every wait is a fixed cycle count.
module tb_palette_ram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_we;
   logic       cpu_re;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       pix_valid;
   logic [2:0] palette_num;
   logic [1:0] color_num;

   logic [5:0] a_rdata, a_sc, b_rdata, b_sc;
   logic       a_rvalid, a_ov, a_busy, b_rvalid, b_ov, b_busy;
   logic [7:0] c_rdata, c_sc;
   logic       c_rvalid, c_ov, c_busy;
   logic [7:0] a_rd8, a_sc8, b_rd8, b_sc8;

   int checks = 0;
   int errors = 0;

   assign a_rd8 = {2'b00, a_rdata};
   assign a_sc8 = {2'b00, a_sc};
   assign b_rd8 = {2'b00, b_rdata};
   assign b_sc8 = {2'b00, b_sc};

   always #5 clk = ~clk;

   palette_ram #(.NUM_PAL(4), .COLORS(4), .COLOR_W(6), .MIRROR_BACKDROP(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr[3:0]), .cpu_wdata(cpu_wdata[5:0]),
      .cpu_rdata(a_rdata), .cpu_rvalid(a_rvalid),
      .pix_valid(pix_valid), .palette_num(palette_num[1:0]), .color_num(color_num),
      .out_valid(a_ov), .system_color(a_sc), .init_busy(a_busy)
   );

   palette_ram #(.NUM_PAL(4), .COLORS(4), .COLOR_W(6), .MIRROR_BACKDROP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr[3:0]), .cpu_wdata(cpu_wdata[5:0]),
      .cpu_rdata(b_rdata), .cpu_rvalid(b_rvalid),
      .pix_valid(pix_valid), .palette_num(palette_num[1:0]), .color_num(color_num),
      .out_valid(b_ov), .system_color(b_sc), .init_busy(b_busy)
   );

   palette_ram #(.NUM_PAL(8), .COLORS(4), .COLOR_W(8), .MIRROR_BACKDROP(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(c_rdata), .cpu_rvalid(c_rvalid),
      .pix_valid(pix_valid), .palette_num(palette_num), .color_num(color_num),
      .out_valid(c_ov), .system_color(c_sc), .init_busy(c_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lookup(input int pal, input int col);
      pix_valid   = 1'b1;
      palette_num = 3'(pal);
      color_num   = 2'(col);
   endtask

   // Counts cycles with init_busy high after reset release; optional probes exercise CPU/pixel traffic during INIT.
   task automatic run_init(input string tag, input bit probe);
      int na = 0;
      int nb = 0;
      int nc = 0;
      for (int i = 0; i < 40; i++) begin
         if (a_busy) na++;
         if (b_busy) nb++;
         if (c_busy) nc++;
         if (probe) begin
            case (i)
               3: begin cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'h2A; end
               4: cpu_we = 1'b0;
               5: lookup(1, 2);
               6: pix_valid = 1'b0;
               7: begin cpu_re = 1'b1; cpu_addr = 5'd5; end
               8: cpu_re = 1'b0;
               default: ;
            endcase
         end
         step();
         if (probe && i == 5) begin
            check({tag, "_init_ov_a"}, {7'b0, a_ov}, 8'h01);
            check({tag, "_init_sc_a"}, a_sc8, 8'h00);
            check({tag, "_init_ov_c"}, {7'b0, c_ov}, 8'h01);
            check({tag, "_init_sc_c"}, c_sc, 8'h00);
         end
         if (probe && i == 7) begin
            check({tag, "_init_rvalid_a"}, {7'b0, a_rvalid}, 8'h00);
            check({tag, "_init_rvalid_c"}, {7'b0, c_rvalid}, 8'h00);
         end
      end
      check({tag, "_busy_cycles_a"}, 8'(na), 8'd16);
      check({tag, "_busy_cycles_b"}, 8'(nb), 8'd16);
      check({tag, "_busy_cycles_c"}, 8'(nc), 8'd32);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         cpu_re   = 1'b1;
         cpu_addr = 5'(i);
         step();
         if (i < 16) begin
            check($sformatf("%s_rv_a[%0d]", tag, i), {7'b0, a_rvalid}, 8'h01);
            check($sformatf("%s_rd_a[%0d]", tag, i), a_rd8, 8'h00);
         end
         check($sformatf("%s_rv_c[%0d]", tag, i), {7'b0, c_rvalid}, 8'h01);
         check($sformatf("%s_rd_c[%0d]", tag, i), c_rdata, 8'h00);
      end
      cpu_re = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_m;
      logic [7:0] exp_u;
      logic [7:0] exp_b [4];

      rst_n = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      pix_valid = 1'b0; palette_num = '0; color_num = '0;

      // Reset held for two edges.
      step();
      step();
      check("rst_busy_a",  {7'b0, a_busy},   8'h01);
      check("rst_rvalid_a",{7'b0, a_rvalid}, 8'h00);
      check("rst_rdata_a", a_rd8,            8'h00);
      check("rst_ov_a",    {7'b0, a_ov},     8'h00);
      check("rst_sc_a",    a_sc8,            8'h00);
      check("rst_busy_c",  {7'b0, c_busy},   8'h01);

      // Release and let all instances clear; INIT writes/reads must be ignored.
      rst_n = 1'b1;
      run_init("init1", 1'b1);
      read_all_zero("clr1");

      // Single write then lookup of palette 1 colour 2.
      cpu_we = 1'b1; cpu_addr = 5'b00110; cpu_wdata = 8'h3C;
      step();
      cpu_we = 1'b0;
      lookup(1, 2);
      step();
      check("wl_ov_a", {7'b0, a_ov}, 8'h01);
      check("wl_sc_a", a_sc8, 8'h3C);
      check("wl_sc_b", b_sc8, 8'h3C);
      check("wl_sc_c", c_sc,  8'h3C);
      pix_valid = 1'b0;
      step();
      check("idle_ov_a", {7'b0, a_ov}, 8'h00);
      check("idle_hold_a", a_sc8, 8'h3C);

      // Fill entries 0..15 with 0x20+i; with mirroring the colour-0 writes land on entry 0, last one 0x2C.
      for (int i = 0; i < 16; i++) begin
         cpu_we = 1'b1; cpu_addr = 5'(i); cpu_wdata = 8'h20 + 8'(i);
         step();
      end
      cpu_we = 1'b0;

      // Stream 16 back-to-back lookups.
      for (int i = 0; i < 16; i++) begin
         lookup(i / 4, i % 4);
         step();
         exp_u = 8'h20 + 8'(i);
         exp_m = ((i % 4) == 0) ? 8'h2C : exp_u;
         check($sformatf("str_ov_a[%0d]", i), {7'b0, a_ov}, 8'h01);
         check($sformatf("str_sc_a[%0d]", i), a_sc8, exp_m);
         check($sformatf("str_sc_b[%0d]", i), b_sc8, exp_u);
         check($sformatf("str_sc_c[%0d]", i), c_sc,  exp_m);
      end
      pix_valid = 1'b0;

      // Backdrop: palette 2 colour 0 = 0x21.
      cpu_we = 1'b1; cpu_addr = 5'b01000; cpu_wdata = 8'h21;
      step();
      cpu_we = 1'b0;
      exp_b[0] = 8'h20; exp_b[1] = 8'h24; exp_b[2] = 8'h21; exp_b[3] = 8'h2C;
      for (int p = 0; p < 4; p++) begin
         lookup(p, 0);
         step();
         check($sformatf("bd_sc_a[%0d]", p), a_sc8, 8'h21);
         check($sformatf("bd_sc_b[%0d]", p), b_sc8, exp_b[p]);
         check($sformatf("bd_sc_c[%0d]", p), c_sc,  8'h21);
      end
      pix_valid = 1'b0;
      cpu_re = 1'b1; cpu_addr = 5'd0;
      step();
      cpu_re = 1'b0;
      check("bd_rd_a", a_rd8,   8'h21);
      check("bd_rd_b", b_rd8,   8'h20);
      check("bd_rd_c", c_rdata, 8'h21);

      // Collision on entry 7: old value returned, new value the cycle after.
      cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 8'h11;
      step();
      cpu_wdata = 8'h22;
      lookup(1, 3);
      step();
      cpu_we = 1'b0;
      check("col_old_a", a_sc8, 8'h11);
      check("col_old_b", b_sc8, 8'h11);
      check("col_old_c", c_sc,  8'h11);
      step();
      check("col_new_a", a_sc8, 8'h22);
      check("col_new_c", c_sc,  8'h22);
      pix_valid = 1'b0;

      // Read handshake on addr 3.
      cpu_re = 1'b1; cpu_addr = 5'd3;
      step();
      cpu_re = 1'b0;
      check("rd_rv_a", {7'b0, a_rvalid}, 8'h01);
      check("rd_d_a",  a_rd8, 8'h23);
      check("rd_d_c",  c_rdata, 8'h23);
      step();
      check("rd_pulse_a", {7'b0, a_rvalid}, 8'h00);
      check("rd_hold_a",  a_rd8, 8'h23);
      cpu_re = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h15;
      step();
      cpu_we = 1'b0;
      check("rw_rv_a",   {7'b0, a_rvalid}, 8'h00);
      check("rw_rv_c",   {7'b0, c_rvalid}, 8'h00);
      check("rw_hold_a", a_rd8, 8'h23);
      step();
      cpu_re = 1'b0;
      check("rw_rv2_a", {7'b0, a_rvalid}, 8'h01);
      check("rw_new_a", a_rd8,   8'h15);
      check("rw_new_c", c_rdata, 8'h15);

      // Reset in the middle of streaming lookups.
      lookup(1, 3);
      step();
      check("mr_pre_sc_a", a_sc8, 8'h22);
      rst_n = 1'b0;
      step();
      check("mr_ov_a",   {7'b0, a_ov},   8'h00);
      check("mr_sc_a",   a_sc8,          8'h00);
      check("mr_busy_a", {7'b0, a_busy}, 8'h01);
      check("mr_ov_c",   {7'b0, c_ov},   8'h00);
      check("mr_busy_c", {7'b0, c_busy}, 8'h01);
      rst_n = 1'b1;
      pix_valid = 1'b0;
      run_init("init2", 1'b0);
      read_all_zero("clr2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
